// File: rtl/aes_decrypt_core.sv
// aes_decrypt_core: iterative AES-128 decryption, one inverse round per clock.
// Ports: clk, rst (synchronous, active high);
//   start, key, cipher_text  - request and operands, sampled only on the accepting edge while bus_free = 1
//   plain_text               - result register, holds the last result until the next completion
//   finish                   - one-cycle pulse when plain_text is updated
//   bus_free                 - high while the core is idle and can accept start
module aes_decrypt_core (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] cipher_text,
  output logic [127:0] plain_text,
  output logic         finish,
  output logic         bus_free
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  localparam logic [2047:0] ISBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };
  typedef enum logic [1:0] {IDLE, KEXP, ROUND} state_t;
  state_t       st, st_n;
  logic [3:0]   cnt, cnt_n;
  logic [127:0] kreg, kreg_n, sreg, sreg_n, pt_n, nk, pk, rs;
  logic         fin_n;
  // Tables are stored byte 0 first, so entry b sits at bit offset 8*(255-b) = {~b, 000}.
  function automatic logic [7:0] sb(input logic [7:0] b);
    logic [10:0] i;
    i = {~b, 3'b000};
    return SBOX[i +: 8];
  endfunction
  function automatic logic [7:0] isb(input logic [7:0] b);
    logic [10:0] i;
    i = {~b, 3'b000};
    return ISBOX[i +: 8];
  endfunction
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  // Multiply by a constant below 16 by summing the doubled terms it selects.
  function automatic logic [7:0] gm(input logic [7:0] b, input logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xt(b);
    x4 = xt(x2);
    x8 = xt(x4);
    return ({8{c[0]}} & b) ^ ({8{c[1]}} & x2) ^ ({8{c[2]}} & x4) ^ ({8{c[3]}} & x8);
  endfunction
  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction
  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {sb(w[23:16]), sb(w[15:8]), sb(w[7:0]), sb(w[31:24])};
  endfunction
  function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction
  // Undo one expansion step: columns 3..1 first, since column 0 needs the recovered w3.
  function automatic logic [127:0] key_bwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0] ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ sub_rot(w3) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction
  // Byte i is row i%4 of column i/4; InvShiftRows fetches row r from column (c - r) mod 4.
  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                              input logic last);
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      t[i] = isb(s[127 - 8 * (4 * (((i / 4) + 4 - (i % 4)) % 4) + (i % 4)) -: 8])
             ^ k[127 - 8 * i -: 8];
    for (int c = 0; c < 4; c++) begin
      a0 = t[4 * c];
      a1 = t[4 * c + 1];
      a2 = t[4 * c + 2];
      a3 = t[4 * c + 3];
      o[127 - 32 * c -: 32] = last ? {a0, a1, a2, a3} :
        {gm(a0, 4'he) ^ gm(a1, 4'hb) ^ gm(a2, 4'hd) ^ gm(a3, 4'h9),
         gm(a0, 4'h9) ^ gm(a1, 4'he) ^ gm(a2, 4'hb) ^ gm(a3, 4'hd),
         gm(a0, 4'hd) ^ gm(a1, 4'h9) ^ gm(a2, 4'he) ^ gm(a3, 4'hb),
         gm(a0, 4'hb) ^ gm(a1, 4'hd) ^ gm(a2, 4'h9) ^ gm(a3, 4'he)};
    end
    return o;
  endfunction
  assign nk       = key_fwd(kreg, rcon(cnt));
  assign pk       = key_bwd(kreg, rcon(cnt + 4'd1));
  assign rs       = inv_round(sreg, pk, cnt == 4'd0);
  assign bus_free = (st == IDLE);
  always_comb begin
    st_n   = st;
    cnt_n  = cnt;
    kreg_n = kreg;
    sreg_n = sreg;
    pt_n   = plain_text;
    fin_n  = 1'b0;
    case (st)
      IDLE: if (start) begin
        kreg_n = key;
        sreg_n = cipher_text;
        cnt_n  = 4'd1;
        st_n   = KEXP;
      end
      KEXP: begin
        kreg_n = nk;
        sreg_n = (cnt == 4'd10) ? sreg ^ nk : sreg;
        cnt_n  = (cnt == 4'd10) ? 4'd9 : cnt + 4'd1;
        st_n   = (cnt == 4'd10) ? ROUND : KEXP;
      end
      ROUND: begin
        kreg_n = pk;
        sreg_n = rs;
        cnt_n  = cnt - 4'd1;
        if (cnt == 4'd0) begin
          pt_n  = rs;
          fin_n = 1'b1;
          st_n  = IDLE;
        end
      end
      default: st_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= IDLE;
      cnt        <= '0;
      kreg       <= '0;
      sreg       <= '0;
      plain_text <= '0;
      finish     <= 1'b0;
    end else begin
      st         <= st_n;
      cnt        <= cnt_n;
      kreg       <= kreg_n;
      sreg       <= sreg_n;
      plain_text <= pt_n;
      finish     <= fin_n;
    end
  end
endmodule

// File: tb/tb_aes_decrypt_core.sv
// tb_aes_decrypt_core: randomized loopback and FIPS-197 checks against a byte-level AES model.
module tb_aes_decrypt_core;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] key = '0;
  logic [127:0] cipher_text = '0;
  logic [127:0] plain_text;
  logic         finish;
  logic         bus_free;
  int           tests = 0;
  int           fails = 0;
  logic [7:0]   sbox [256];
  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;

  aes_decrypt_core dut (
    .clk(clk), .rst(rst), .start(start), .key(key), .cipher_text(cipher_text),
    .plain_text(plain_text), .finish(finish), .bus_free(bus_free)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box derived from first principles: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] p);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rk [176];
    logic [7:0]   w [4];
    logic [7:0]   rc, tmp;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) begin
      rk[i] = k[127 - 8 * i -: 8];
      s[i]  = p[127 - 8 * i -: 8];
    end
    rc = 8'h01;
    for (int i = 16; i < 176; i += 4) begin
      for (int j = 0; j < 4; j++) w[j] = rk[i - 4 + j];
      if (i % 16 == 0) begin
        tmp  = w[0];
        w[0] = sbox[w[1]] ^ rc;
        w[1] = sbox[w[2]];
        w[2] = sbox[w[3]];
        w[3] = sbox[tmp];
        rc   = gmul(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) rk[i + j] = rk[i - 16 + j] ^ w[j];
    end
    for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[i];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4 * c + r] = s[4 * ((c + r) % 4) + r];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[4 * c + r] = (rnd == 10) ? t[4 * c + r] :
            gmul(8'h02, t[4 * c + r]) ^ gmul(8'h03, t[4 * c + (r + 1) % 4])
            ^ t[4 * c + (r + 2) % 4] ^ t[4 * c + (r + 3) % 4];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[16 * rnd + i];
    end
    for (int i = 0; i < 16; i++) o[127 - 8 * i -: 8] = s[i];
    return o;
  endfunction

  // Presents a request so that it is taken at the next rising edge, then scrambles the operands.
  task automatic accept(input logic [127:0] k, input logic [127:0] c);
    @(negedge clk);
    start       = 1'b1;
    key         = k;
    cipher_text = c;
    @(posedge clk);
    #1;
    start       = 1'b0;
    key         = rnd128();
    cipher_text = rnd128();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (plain_text !== 128'h0) begin
      fails++;
      $display("FAIL reset plain_text: got %h want 0", plain_text);
    end
    tests++;
    if (finish !== 1'b0) begin
      fails++;
      $display("FAIL reset finish: got %b want 0", finish);
    end
    tests++;
    if (bus_free !== 1'b1) begin
      fails++;
      $display("FAIL reset bus_free: got %b want 1", bus_free);
    end
    @(negedge clk);
    start       = 1'b1;
    key         = KB;
    cipher_text = CB;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    tests++;
    if (bus_free !== 1'b1) begin
      fails++;
      $display("FAIL rst_over_start bus_free: got %b want 1", bus_free);
    end
    @(posedge clk);
    #1;
    tests++;
    if (bus_free !== 1'b1 || finish !== 1'b0) begin
      fails++;
      $display("FAIL rst_over_start idle: got bus_free=%b finish=%b want 1/0", bus_free, finish);
    end
  endtask

  task automatic test_fips_b();
    logic e;
    accept(KB, CB);
    for (int n = 0; n <= 20; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
      e = (n == 20);
      tests++;
      if (bus_free !== e) begin
        fails++;
        $display("FAIL fips_b bus_free cycle %0d: got %b want %b", n, bus_free, e);
      end
      tests++;
      if (finish !== e) begin
        fails++;
        $display("FAIL fips_b finish cycle %0d: got %b want %b", n, finish, e);
      end
    end
    tests++;
    if (plain_text !== PB) begin
      fails++;
      $display("FAIL fips_b plain_text: got %h want %h", plain_text, PB);
    end
  endtask

  task automatic test_fips_c();
    int cyc;
    accept(KC, CC);
    cyc = 0;
    while (finish !== 1'b1 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    tests++;
    if (cyc != 20) begin
      fails++;
      $display("FAIL fips_c latency: got %0d want 20", cyc);
    end
    tests++;
    if (plain_text !== PC) begin
      fails++;
      $display("FAIL fips_c plain_text: got %h want %h", plain_text, PC);
    end
  endtask

  task automatic test_loopback();
    logic [127:0] k, p, c;
    int cyc;
    for (int b = 0; b < 8; b++) begin
      k = rnd128();
      p = rnd128();
      c = aes_enc(k, p);
      accept(k, c);
      cyc = 0;
      while (finish !== 1'b1 && cyc < 40) begin
        @(posedge clk);
        #1;
        cyc++;
      end
      tests++;
      if (cyc != 20) begin
        fails++;
        $display("FAIL loopback %0d latency: got %0d want 20", b, cyc);
      end
      tests++;
      if (plain_text !== p) begin
        fails++;
        $display("FAIL loopback %0d plain_text: got %h want %h", b, plain_text, p);
      end
    end
  endtask

  task automatic test_ignored_start();
    int extra;
    accept(KB, CB);
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (n == 4) begin
        start       = 1'b1;
        key         = KC;
        cipher_text = rnd128();
      end
      if (n == 5) start = 1'b0;
      tests++;
      if (finish !== (n == 20)) begin
        fails++;
        $display("FAIL ignored_start finish cycle %0d: got %b want %b", n, finish, n == 20);
      end
    end
    tests++;
    if (plain_text !== PB) begin
      fails++;
      $display("FAIL ignored_start plain_text: got %h want %h", plain_text, PB);
    end
    extra = 0;
    for (int n = 0; n < 25; n++) begin
      @(posedge clk);
      #1;
      if (finish === 1'b1 || bus_free !== 1'b1) extra++;
    end
    tests++;
    if (extra != 0) begin
      fails++;
      $display("FAIL ignored_start aftermath: got %0d busy/finish cycles want 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    accept(KB, CB);
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
    end
    tests++;
    if (finish !== 1'b1 || plain_text !== PB) begin
      fails++;
      $display("FAIL b2b first: got finish=%b plain_text=%h want 1 %h", finish, plain_text, PB);
    end
    accept(KC, CC);
    for (int m = 0; m <= 20; m++) begin
      if (m > 0) begin
        @(posedge clk);
        #1;
      end
      tests++;
      if (finish !== (m == 20) || plain_text !== ((m == 20) ? PC : PB)) begin
        fails++;
        $display("FAIL b2b second cycle %0d: got finish=%b plain_text=%h want %b %h",
                 m, finish, plain_text, m == 20, (m == 20) ? PC : PB);
      end
    end
  endtask

  task automatic test_start_held();
    int cnt;
    @(negedge clk);
    start       = 1'b1;
    key         = KC;
    cipher_text = CC;
    cnt = 0;
    for (int n = 1; n <= 70; n++) begin
      @(posedge clk);
      #1;
      if (finish === 1'b1) begin
        cnt++;
        tests++;
        if (plain_text !== PC) begin
          fails++;
          $display("FAIL start_held plain_text: got %h want %h", plain_text, PC);
        end
      end
    end
    start = 1'b0;
    tests++;
    if (cnt != 3) begin
      fails++;
      $display("FAIL start_held finishes: got %0d want 3", cnt);
    end
    repeat (30) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int extra;
    accept(KB, CB);
    for (int n = 1; n <= 11; n++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tests++;
    if (plain_text !== 128'h0 || bus_free !== 1'b1 || finish !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: got plain_text=%h bus_free=%b finish=%b want 0 1 0",
               plain_text, bus_free, finish);
    end
    extra = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk);
      #1;
      if (finish === 1'b1) extra++;
    end
    tests++;
    if (extra != 0) begin
      fails++;
      $display("FAIL reset_mid finish pulses: got %0d want 0", extra);
    end
    test_fips_c();
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips_b();
    test_fips_c();
    test_loopback();
    test_ignored_start();
    test_back_to_back();
    test_start_held();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
